// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Used by the transmitter and the future receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BAUD_DIV_DEFAULT = 10417;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate divider.
// tick fires one cycle in every BAUD_DIV, phase set by clear.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W =
        (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..BAUD_DIV-1 and wrap so bit periods never drift.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with built-in baud divider.
// Outputs are registered; no input reaches them combinationally.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_status,
    output logic       uart_txd
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'(DATA_BITS - 1);

    uart_state_e          state;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 tick;
    logic                 baud_clear;

    // Hold the divider at phase 0 while idle so the
    // start bit lasts a full period after acceptance.
    assign baud_clear = (state == IDLE);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    // Frame sequencer: IDLE -> START -> DATA -> STOP -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_idx   <= '0;
            uart_txd  <= UART_IDLE_LEVEL;
            tx_status <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    uart_txd  <= UART_IDLE_LEVEL;
                    tx_status <= 1'b1;
                    if (tx_en) begin
                        shift     <= tx_data;
                        uart_txd  <= ~UART_IDLE_LEVEL;
                        tx_status <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_idx  <= '0;
                        uart_txd <= shift[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= shift >> 1;
                        if (bit_idx == LAST_IDX) begin
                            uart_txd <= UART_IDLE_LEVEL;
                            state    <= STOP;
                        end else begin
                            uart_txd <= shift[1];
                            bit_idx  <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tx_status <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
